// File: rtl/sd_spi_burst_engine.sv
// sd_spi_burst_engine
//   SPI mode 0 (MSB first) byte engine for an SD card in SPI mode. Runs bursts of
//   len_i+1 bytes. The SCLK half-period is div_i+1 clk. Each burst either streams
//   tx bytes or sends FILL_BYTE. CS can be held after a burst, or kept deasserted
//   for the power-up clock train.
//
//   Stream handshakes: a byte moves on a rising clk edge where valid and ready
//   are both 1. A producer keeps valid and data stable until that edge.
//   rx_valid_o is held with a stable rx_data_o until rx_ready_i accepts it.
//   tx_ready_o is a combinational function of state and abort_i.
//
// Ports
//   clk, reset                 system clock, asynchronous active-high reset
//   start_i, div_i, len_i      burst request and its parameters (latched at start)
//   tx_mode_i, cs_hold_i       tx stream vs fill byte; keep CS low after burst
//   cs_inactive_i              run the burst with CS deasserted
//   abort_i                    synchronous abort, releases CS
//   tx_data_i/valid_i/ready_o  tx byte stream
//   rx_data_o/valid_o/ready_i  rx byte stream
//   busy_o, done_o             burst in progress, 1-cycle end pulse
//   sd_clk_o, sd_cs_n_o,       SD pins
//   sd_mosi_o, sd_miso_i
//   state_o                    current FSM state (debug)
module sd_spi_burst_engine #(
    parameter int         DIV_W     = 8,
    parameter int         LEN_W     = 10,
    parameter logic [7:0] FILL_BYTE = 8'hFF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic [DIV_W-1:0] div_i,
    input  logic [LEN_W-1:0] len_i,
    input  logic             tx_mode_i,
    input  logic             cs_hold_i,
    input  logic             cs_inactive_i,
    input  logic             abort_i,
    input  logic [7:0]       tx_data_i,
    input  logic             tx_valid_i,
    output logic             tx_ready_o,
    output logic [7:0]       rx_data_o,
    output logic             rx_valid_o,
    input  logic             rx_ready_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             sd_clk_o,
    output logic             sd_cs_n_o,
    output logic             sd_mosi_o,
    input  logic             sd_miso_i,
    output logic [2:0]       state_o
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_LOW     = 3'd2,
        S_HIGH    = 3'd3,
        S_HANDOFF = 3'd4,
        S_END     = 3'd5
    } state_t;

    localparam logic [DIV_W-1:0] DIV_ONE = {{(DIV_W-1){1'b0}}, 1'b1};
    localparam logic [LEN_W-1:0] LEN_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_cnt_q;
    logic [LEN_W-1:0] len_q, byte_cnt_q;
    logic             tx_mode_q, cs_hold_q, cs_inact_q, cs_active_q;
    logic [2:0]       bit_cnt_q;
    logic [7:0]       tx_sh_q, rx_sh_q;
    logic             fill_mode, half_done, last_byte;

    assign fill_mode = !tx_mode_q || cs_inact_q;
    assign half_done = (div_cnt_q == div_q);
    // Termination compares before incrementing, so byte_cnt never wraps even at len=max.
    assign last_byte = (byte_cnt_q == len_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (abort_i) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:    if (start_i) state_d = S_LOAD;
                S_LOAD:    if (fill_mode || tx_valid_i) state_d = S_LOW;
                S_LOW:     if (half_done) state_d = S_HIGH;
                S_HIGH:    if (half_done) state_d = (bit_cnt_q == 3'd7) ? S_HANDOFF : S_LOW;
                S_HANDOFF: if (rx_ready_i) state_d = last_byte ? S_END : S_LOAD;
                S_END:     state_d = S_IDLE;
                default:   state_d = S_IDLE;
            endcase
        end
    end

    // Datapath: burst parameters, counters, shift registers, CS latch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q       <= '0;
            len_q       <= '0;
            tx_mode_q   <= 1'b0;
            cs_hold_q   <= 1'b0;
            cs_inact_q  <= 1'b0;
            cs_active_q <= 1'b0;
            byte_cnt_q  <= '0;
            bit_cnt_q   <= 3'd0;
            div_cnt_q   <= '0;
            tx_sh_q     <= 8'h00;
            rx_sh_q     <= 8'h00;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        div_q       <= div_i;
                        len_q       <= len_i;
                        tx_mode_q   <= tx_mode_i;
                        cs_hold_q   <= cs_hold_i;
                        cs_inact_q  <= cs_inactive_i;
                        byte_cnt_q  <= '0;
                        cs_active_q <= !cs_inactive_i;
                    end
                end
                S_LOAD: begin
                    tx_sh_q   <= fill_mode ? FILL_BYTE : tx_data_i;
                    bit_cnt_q <= 3'd0;
                    div_cnt_q <= '0;
                end
                S_LOW: begin
                    div_cnt_q <= half_done ? '0 : div_cnt_q + DIV_ONE;
                    // The LOW->HIGH transition is the SCLK rising edge.
                    if (half_done) rx_sh_q <= {rx_sh_q[6:0], sd_miso_i};
                end
                S_HIGH: begin
                    div_cnt_q <= half_done ? '0 : div_cnt_q + DIV_ONE;
                    if (half_done && bit_cnt_q != 3'd7) begin
                        tx_sh_q   <= {tx_sh_q[6:0], 1'b1};
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                    end
                end
                S_HANDOFF: begin
                    if (rx_ready_i) begin
                        if (!last_byte)     byte_cnt_q  <= byte_cnt_q + LEN_ONE;
                        else if (!cs_hold_q) cs_active_q <= 1'b0;
                    end
                end
                default: ;
            endcase
            if (abort_i) cs_active_q <= 1'b0;
        end
    end

    always_comb begin
        tx_ready_o = (state_q == S_LOAD) && !fill_mode && !abort_i;
        rx_valid_o = (state_q == S_HANDOFF);
        rx_data_o  = rx_sh_q;
        busy_o     = (state_q != S_IDLE);
        done_o     = (state_q == S_END);
        sd_clk_o   = (state_q == S_HIGH);
        sd_mosi_o  = (state_q == S_LOW || state_q == S_HIGH) ? tx_sh_q[7] : 1'b1;
        sd_cs_n_o  = !cs_active_q;
        state_o    = state_q;
    end

endmodule

// File: tb/tb_sd_spi_burst_engine.sv
module tb_sd_spi_burst_engine;

  logic       clk = 1'b0;
  logic       reset;
  logic       start_i, tx_mode_i, cs_hold_i, cs_inactive_i, abort_i;
  logic [7:0] div_i;
  logic [9:0] len_i;
  logic [7:0] tx_data_i, rx_data_o;
  logic       tx_valid_i, tx_ready_o, rx_valid_o, rx_ready_i;
  logic       busy_o, done_o, sd_clk_o, sd_cs_n_o, sd_mosi_o, sd_miso_i;
  logic [2:0] state_o;
  logic       loop_en, card_miso;

  logic [7:0] exp_q[$];
  int total = 0;
  int bad = 0;

  // Card side: loopback of MOSI, or a byte source shifted on SCLK falling edges.
  assign sd_miso_i = loop_en ? sd_mosi_o : card_miso;

  always #5 clk = ~clk;

  sd_spi_burst_engine dut (
    .clk(clk), .reset(reset), .start_i(start_i), .div_i(div_i), .len_i(len_i),
    .tx_mode_i(tx_mode_i), .cs_hold_i(cs_hold_i), .cs_inactive_i(cs_inactive_i),
    .abort_i(abort_i), .tx_data_i(tx_data_i), .tx_valid_i(tx_valid_i),
    .tx_ready_o(tx_ready_o), .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o),
    .rx_ready_i(rx_ready_i), .busy_o(busy_o), .done_o(done_o), .sd_clk_o(sd_clk_o),
    .sd_cs_n_o(sd_cs_n_o), .sd_mosi_o(sd_mosi_o), .sd_miso_i(sd_miso_i),
    .state_o(state_o)
  );

  typedef struct packed {
    logic [7:0]  div;
    logic [9:0]  len;
    logic        tx_mode;
    logic        cs_hold;
    logic        cs_inact;
    logic        loopback;
    logic        stall;
    logic [31:0] tx_bytes;
    logic [31:0] card_bytes;
    logic [31:0] exp_rx;
    logic [15:0] exp_rises;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, act, exp);
    end
  endtask

  // Byte i of a packed 4-byte word, first byte in the MSBs; 0xFF beyond the word.
  function automatic logic [7:0] b4(input logic [31:0] w, input int i);
    logic [31:0] t;
    if (i > 3) return 8'hFF;
    t = w >> (8 * (3 - i));
    return t[7:0];
  endfunction

  task automatic run_vec(input int vid, input vec_t v);
    int n, budget, rises, hi_len, lo_len, half_bad, lo_bad, cs_bad, txr_bad, mosi_bad;
    int stall_bad, stall_cnt, dones, nrx, mbits, tx_idx, card_idx, card_bit;
    logic [7:0] mosi_sh, stall_data, card_byte, exp_m, e;
    logic prev_sc, sc, tx_pend, fin, fill;
    n = int'(v.len) + 1;
    fill = !v.tx_mode || v.cs_inact;
    rises = 0; hi_len = 0; lo_len = 0; half_bad = 0; lo_bad = 0; cs_bad = 0; txr_bad = 0;
    mosi_bad = 0; stall_bad = 0; stall_cnt = 0; dones = 0; nrx = 0; mbits = 0;
    tx_idx = 0; card_idx = 0; card_bit = 0; mosi_sh = 8'h00; stall_data = 8'h00;
    prev_sc = 1'b0; tx_pend = 1'b0; fin = 1'b0;
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back(b4(v.exp_rx, i));
    @(negedge clk);
    loop_en = v.loopback;
    card_byte = b4(v.card_bytes, 0);
    card_miso = card_byte[7];
    tx_data_i = b4(v.tx_bytes, 0);
    tx_valid_i = v.tx_mode;
    rx_ready_i = !v.stall;
    div_i = v.div; len_i = v.len; tx_mode_i = v.tx_mode; cs_hold_i = v.cs_hold;
    cs_inactive_i = v.cs_inact; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    budget = n * (16 * (int'(v.div) + 1) + 4) + 60;
    for (int c = 0; c < budget && !fin; c++) begin
      if (tx_pend) begin
        tx_idx++;
        tx_data_i = b4(v.tx_bytes, tx_idx);
        tx_valid_i = v.tx_mode && (tx_idx < n);
        tx_pend = 1'b0;
      end
      sc = sd_clk_o;
      if (state_o == 3'd2) lo_len++;
      if (sc && !prev_sc) begin
        rises++;
        if (lo_len != int'(v.div) + 1) lo_bad++;
        lo_len = 0;
        mosi_sh = {mosi_sh[6:0], sd_mosi_o};
        mbits++;
        if (mbits % 8 == 0) begin
          exp_m = fill ? 8'hFF : b4(v.tx_bytes, mbits / 8 - 1);
          if (mosi_sh != exp_m) mosi_bad++;
        end
      end
      if (sc) hi_len++;
      if (!sc && prev_sc) begin
        if (hi_len != int'(v.div) + 1) half_bad++;
        hi_len = 0;
        card_bit++;
        if (card_bit == 8) begin
          card_bit = 0;
          card_idx++;
        end
        card_byte = b4(v.card_bytes, card_idx);
        card_miso = card_byte[7 - card_bit];
      end
      if (v.cs_inact && !sd_cs_n_o) cs_bad++;
      if (!v.cs_inact && busy_o && !done_o && sd_cs_n_o) cs_bad++;
      if (tx_ready_o && fill) txr_bad++;
      if (fill && !sd_mosi_o) mosi_bad++;
      if (tx_ready_o && tx_valid_i) tx_pend = 1'b1;
      if (rx_valid_o && v.stall && nrx == 0 && stall_cnt < 20) begin
        if (stall_cnt == 0) stall_data = rx_data_o;
        else if (rx_data_o != stall_data || sc || sd_cs_n_o) stall_bad++;
        stall_cnt++;
        start_i = 1'b1;  // must be ignored while busy
        if (stall_cnt == 20) begin
          rx_ready_i = 1'b1;
          start_i = 1'b0;
        end
      end
      if (rx_valid_o && rx_ready_i) begin
        nrx++;
        if (exp_q.size() == 0) check($sformatf("v%0d_rx_extra", vid), 32'(rx_data_o), 32'h0);
        else begin
          e = exp_q.pop_front();
          check($sformatf("v%0d_rx%0d", vid, nrx - 1), 32'(rx_data_o), 32'(e));
        end
      end
      if (done_o) begin
        dones++;
        fin = 1'b1;
      end
      prev_sc = sc;
      @(negedge clk);
    end
    tx_valid_i = 1'b0;
    start_i = 1'b0;
    rx_ready_i = 1'b1;
    check($sformatf("v%0d_timeout", vid), 32'(fin), 32'd1);
    check($sformatf("v%0d_done_cnt", vid), 32'(dones), 32'd1);
    check($sformatf("v%0d_done_1cyc", vid), 32'(done_o), 32'd0);
    check($sformatf("v%0d_busy_end", vid), 32'(busy_o), 32'd0);
    check($sformatf("v%0d_rises", vid), 32'(rises), 32'(v.exp_rises));
    check($sformatf("v%0d_rx_cnt", vid), 32'(nrx), 32'(n));
    check($sformatf("v%0d_hi_half", vid), 32'(half_bad), 32'd0);
    check($sformatf("v%0d_lo_half", vid), 32'(lo_bad), 32'd0);
    check($sformatf("v%0d_cs", vid), 32'(cs_bad), 32'd0);
    check($sformatf("v%0d_txready", vid), 32'(txr_bad), 32'd0);
    check($sformatf("v%0d_mosi", vid), 32'(mosi_bad), 32'd0);
    check($sformatf("v%0d_cs_idle", vid), 32'(sd_cs_n_o), 32'((v.cs_hold && !v.cs_inact) ? 0 : 1));
    if (v.stall) begin
      check($sformatf("v%0d_stall", vid), 32'(stall_bad), 32'd0);
      check($sformatf("v%0d_stall_len", vid), 32'(stall_cnt), 32'd20);
    end
  endtask

  initial begin
    int r, dn;
    logic ok;
    vecs[0] = '{div:8'd0,  len:10'd0, tx_mode:1'b1, cs_hold:1'b0, cs_inact:1'b0, loopback:1'b1,
                stall:1'b0, tx_bytes:32'hA5000000, card_bytes:32'h0, exp_rx:32'hA5000000, exp_rises:16'd8};
    vecs[1] = '{div:8'd3,  len:10'd3, tx_mode:1'b0, cs_hold:1'b0, cs_inact:1'b0, loopback:1'b0,
                stall:1'b0, tx_bytes:32'h0, card_bytes:32'h01FE55AA, exp_rx:32'h01FE55AA, exp_rises:16'd32};
    vecs[2] = '{div:8'd0,  len:10'd3, tx_mode:1'b0, cs_hold:1'b0, cs_inact:1'b0, loopback:1'b0,
                stall:1'b1, tx_bytes:32'h0, card_bytes:32'h5A0FC381, exp_rx:32'h5A0FC381, exp_rises:16'd32};
    vecs[3] = '{div:8'd62, len:10'd9, tx_mode:1'b1, cs_hold:1'b0, cs_inact:1'b1, loopback:1'b0,
                stall:1'b0, tx_bytes:32'h12345678, card_bytes:32'hFFFFFFFF, exp_rx:32'hFFFFFFFF, exp_rises:16'd80};
    vecs[4] = '{div:8'd1,  len:10'd2, tx_mode:1'b1, cs_hold:1'b1, cs_inact:1'b0, loopback:1'b1,
                stall:1'b0, tx_bytes:32'h3C00FF00, card_bytes:32'h0, exp_rx:32'h3C00FF00, exp_rises:16'd24};
    vecs[5] = '{div:8'd2,  len:10'd1, tx_mode:1'b1, cs_hold:1'b0, cs_inact:1'b0, loopback:1'b0,
                stall:1'b0, tx_bytes:32'h12340000, card_bytes:32'hC35A0000, exp_rx:32'hC35A0000, exp_rises:16'd16};

    // Clock/reset
    reset = 1'b1; start_i = 1'b0; div_i = '0; len_i = '0; tx_mode_i = 1'b0; cs_hold_i = 1'b0;
    cs_inactive_i = 1'b0; abort_i = 1'b0; tx_data_i = 8'h00; tx_valid_i = 1'b0;
    rx_ready_i = 1'b1; loop_en = 1'b0; card_miso = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_sclk", 32'(sd_clk_o), 32'd0);
    check("rst_cs_n", 32'(sd_cs_n_o), 32'd1);
    check("rst_mosi", 32'(sd_mosi_o), 32'd1);
    check("rst_rx_data", 32'(rx_data_o), 32'd0);
    check("rst_flags", {28'd0, tx_ready_o, rx_valid_o, busy_o, done_o}, 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Table-driven bursts: loopback, fill read, stalled read, init clocks.
    for (int i = 0; i < 4; i++) run_vec(i, vecs[i]);

    // Held CS across bursts, release by a cs_hold=0 burst, then release by abort in idle.
    run_vec(4, vecs[4]);
    repeat (5) @(negedge clk);
    check("cs_held_idle", 32'(sd_cs_n_o), 32'd0);
    run_vec(5, vecs[5]);
    run_vec(4, vecs[4]);
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    check("abort_idle_cs", 32'(sd_cs_n_o), 32'd1);

    // Abort mid-burst: no done pulse, everything idle on the next cycle.
    loop_en = 1'b0; card_miso = 1'b0;
    div_i = 8'd3; len_i = 10'd3; tx_mode_i = 1'b0; cs_hold_i = 1'b0; cs_inactive_i = 1'b0;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (40) @(negedge clk);
    check("abort_pre_busy", 32'(busy_o), 32'd1);
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    check("abort_state", {27'd0, busy_o, sd_clk_o, sd_cs_n_o, sd_mosi_o, rx_valid_o}, 32'b00110);
    dn = 0;
    for (int i = 0; i < 5; i++) begin
      if (done_o || busy_o) dn++;
      @(negedge clk);
    end
    check("abort_no_done", 32'(dn), 32'd0);

    // Abort wins over a simultaneous start.
    start_i = 1'b1; abort_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0; abort_i = 1'b0;
    check("abort_vs_start", {30'd0, busy_o, sd_cs_n_o}, 32'b01);

    // Reset at bit 4 of byte 1 (13th rising SCLK edge), then a clean burst.
    div_i = 8'd1; len_i = 10'd2; tx_mode_i = 1'b0; rx_ready_i = 1'b1;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    r = 0; ok = 1'b0;
    for (int c = 0; c < 400 && !ok; c++) begin
      if (sd_clk_o) begin
        r++;
        if (r == 13) ok = 1'b1;
        while (sd_clk_o && !ok) @(negedge clk);
      end
      if (!ok) @(negedge clk);
    end
    check("rst_mid_reach", 32'(ok), 32'd1);
    reset = 1'b1;
    #1;
    check("rst_mid_pins", {29'd0, sd_clk_o, sd_cs_n_o, sd_mosi_o}, 32'b011);
    check("rst_mid_flags", {28'd0, busy_o, rx_valid_o, done_o, tx_ready_o}, 32'd0);
    check("rst_mid_rx", 32'(rx_data_o), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    run_vec(1, vecs[1]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
